// File: rtl/lif_spike_neuron.sv
// Leaky integrate-and-fire neuron with saturating unsigned membrane potential,
// periodic shift-based leak and an absolute refractory period after each spike.
module lif_spike_neuron #(
  parameter int WIDTH       = 8,
  parameter int W_EXC       = 16,
  parameter int W_INH       = 16,
  parameter int THRESH      = 128,
  parameter int LEAK_SHIFT  = 3,
  parameter int LEAK_PERIOD = 64,
  parameter int REFRACT     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             excIn,
  input  logic             inhIn,
  output logic             spikeOut,
  output logic [WIDTH-1:0] potential,
  output logic             refractory
);

  localparam int LCW = (LEAK_PERIOD > 1) ? $clog2(LEAK_PERIOD) : 1;
  localparam int RCW = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
  localparam int SW  = WIDTH + 2;

  localparam logic [LCW-1:0]        LEAK_LAST = LCW'(LEAK_PERIOD - 1);
  localparam logic [RCW-1:0]        REF_LOAD  = RCW'(REFRACT);
  localparam logic signed [SW-1:0]  EXC_S     = SW'(W_EXC);
  localparam logic signed [SW-1:0]  INH_S     = SW'(W_INH);
  localparam logic [WIDTH-1:0]      THRESH_V  = WIDTH'(THRESH);
  localparam logic [WIDTH-1:0]      POT_MAX   = '1;

  typedef enum logic {INTEGRATE, REFRACTORY} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pot_q, pot_d;
  logic             spike_q, spike_d;
  logic             refr_q, refr_d;
  logic [LCW-1:0]   leak_cnt_q, leak_cnt_d;
  logic [RCW-1:0]   ref_cnt_q, ref_cnt_d;

  logic                 leak_tick;
  logic signed [SW-1:0] next_s;
  logic [WIDTH-1:0]     next_clamped;

  assign leak_tick = (leak_cnt_q == LEAK_LAST);

  // Two guard bits: the top one flags underflow, the next one flags overflow.
  always_comb begin
    next_s = signed'({2'b00, pot_q});
    if (excIn)     next_s = next_s + EXC_S;
    if (inhIn)     next_s = next_s - INH_S;
    if (leak_tick) next_s = next_s - signed'({2'b00, pot_q >> LEAK_SHIFT});
    if (next_s[SW-1])      next_clamped = '0;
    else if (next_s[WIDTH]) next_clamped = POT_MAX;
    else                    next_clamped = next_s[WIDTH-1:0];
  end

  always_comb begin
    // NOTE: every _d gets a hold/default value first so no path can infer a latch.
    state_d    = state_q;
    pot_d      = pot_q;
    spike_d    = 1'b0;
    refr_d     = refr_q;
    leak_cnt_d = leak_cnt_q;
    ref_cnt_d  = ref_cnt_q;
    if (enable) begin
      leak_cnt_d = leak_tick ? '0 : leak_cnt_q + LCW'(1);
      case (state_q)
        INTEGRATE: begin
          if (next_clamped >= THRESH_V) begin
            pot_d   = '0;
            spike_d = 1'b1;
            if (REFRACT > 0) begin
              state_d   = REFRACTORY;
              ref_cnt_d = REF_LOAD;
              refr_d    = 1'b1;
            end
          end else begin
            pot_d = next_clamped;
          end
        end
        REFRACTORY: begin
          pot_d = '0;
          if (ref_cnt_q == RCW'(1)) begin
            ref_cnt_d = '0;
            refr_d    = 1'b0;
            state_d   = INTEGRATE;
          end else begin
            ref_cnt_d = ref_cnt_q - RCW'(1);
          end
        end
        default: state_d = INTEGRATE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= INTEGRATE;
      pot_q      <= '0;
      spike_q    <= 1'b0;
      refr_q     <= 1'b0;
      leak_cnt_q <= '0;
      ref_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      pot_q      <= pot_d;
      spike_q    <= spike_d;
      refr_q     <= refr_d;
      leak_cnt_q <= leak_cnt_d;
      ref_cnt_q  <= ref_cnt_d;
    end
  end

  assign spikeOut   = spike_q;
  assign potential  = pot_q;
  assign refractory = refr_q;

endmodule

// File: tb/tb_lif_spike_neuron.sv
// Scoreboard bench for lif_spike_neuron: the driver queues hand-computed
// expectations per cycle, the monitor pops and compares on the falling edge.
module tb_lif_spike_neuron;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       excIn;
  logic       inhIn;
  logic       spikeOut;
  logic [7:0] potential;
  logic       refractory;

  typedef struct {
    string      tag;
    logic       spk;
    logic [7:0] pot;
    logic       refr;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  lif_spike_neuron dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .excIn     (excIn),
    .inhIn     (inhIn),
    .spikeOut  (spikeOut),
    .potential (potential),
    .refractory(refractory)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue the outputs expected after that edge.
  task automatic step(input logic r, input logic en, input logic e, input logic i,
                      input logic exp_spk, input logic [7:0] exp_pot,
                      input logic exp_refr, input string tag);
    exp_t x;
    @(negedge clk);
    rst = r; enable = en; excIn = e; inhIn = i;
    @(posedge clk);
    x.tag = tag; x.spk = exp_spk; x.pot = exp_pot; x.refr = exp_refr;
    exp_q.push_back(x);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t x;
      x = exp_q.pop_front();
      n_checks++;
      if (spikeOut === x.spk && potential === x.pot && refractory === x.refr)
        n_pass++;
      else
        $display("FAIL %s: got spike=%b pot=%0d refr=%b, want spike=%b pot=%0d refr=%b",
                 x.tag, spikeOut, potential, refractory, x.spk, x.pot, x.refr);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; enable = 1'b0; excIn = 1'b0; inhIn = 1'b0;

    // Reset, then charge to threshold with eight excitatory cycles.
    step(1, 1, 0, 0, 0, 0, 0, "reset0");
    step(1, 1, 0, 0, 0, 0, 0, "reset1");
    for (int i = 0; i < 7; i++) step(0, 1, 1, 0, 0, 8'(16 * (i + 1)), 0, "exc_ramp");
    step(0, 1, 1, 0, 1, 0, 1, "first_spike");
    // Refractory window ignores excitation for exactly 16 enabled cycles.
    for (int i = 0; i < 15; i++) step(0, 1, 1, 0, 0, 0, 1, "refract_hold");
    step(0, 1, 1, 0, 0, 0, 0, "refract_exit");
    step(0, 1, 1, 0, 0, 16, 0, "post_refract");

    // Leak: 80 -> 70 at the first tick, 70 -> 62 at the next.
    step(1, 1, 0, 0, 0, 0, 0, "reset_leak");
    for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 0, 8'(16 * (i + 1)), 0, "leak_charge");
    for (int i = 0; i < 58; i++) step(0, 1, 0, 0, 0, 80, 0, "leak_idle1");
    step(0, 1, 0, 0, 0, 70, 0, "leak_tick1");
    for (int i = 0; i < 63; i++) step(0, 1, 0, 0, 0, 70, 0, "leak_idle2");
    step(0, 1, 0, 0, 0, 62, 0, "leak_tick2");

    // Simultaneous inputs cancel; inhibition clamps at zero.
    step(1, 1, 0, 0, 0, 0, 0, "reset_inh");
    step(0, 1, 1, 0, 0, 16, 0, "inh_charge");
    step(0, 1, 1, 0, 0, 32, 0, "inh_charge");
    step(0, 1, 1, 1, 0, 32, 0, "exc_and_inh");
    step(0, 1, 0, 1, 0, 16, 0, "inh_1");
    step(0, 1, 0, 1, 0, 0, 0, "inh_2");
    step(0, 1, 0, 1, 0, 0, 0, "inh_clamp");

    // Disabled cycles freeze potential and the leak counter.
    step(1, 1, 0, 0, 0, 0, 0, "reset_en");
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 8'(16 * (i + 1)), 0, "en_charge");
    for (int i = 0; i < 10; i++) step(0, 0, 1, 0, 0, 48, 0, "disabled_hold");
    step(0, 1, 1, 0, 0, 64, 0, "reenable");
    for (int i = 0; i < 59; i++) step(0, 1, 0, 0, 0, 64, 0, "en_idle");
    step(0, 1, 0, 0, 0, 56, 0, "leak_after_freeze");

    // Disabling right after a spike must not stretch it; refractory count is held.
    step(1, 1, 0, 0, 0, 0, 0, "reset_stretch");
    for (int i = 0; i < 7; i++) step(0, 1, 1, 0, 0, 8'(16 * (i + 1)), 0, "stretch_ramp");
    step(0, 1, 1, 0, 1, 0, 1, "stretch_spike");
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, 0, 1, "spike_not_stretched");
    for (int i = 0; i < 15; i++) step(0, 1, 1, 0, 0, 0, 1, "frozen_refract_hold");
    step(0, 1, 1, 0, 0, 0, 0, "frozen_refract_exit");
    step(0, 1, 1, 0, 0, 16, 0, "frozen_post_refract");

    // Reset in the middle of refractory (counter at 7), then spike again normally.
    step(1, 1, 0, 0, 0, 0, 0, "reset_mid");
    for (int i = 0; i < 7; i++) step(0, 1, 1, 0, 0, 8'(16 * (i + 1)), 0, "mid_ramp");
    step(0, 1, 1, 0, 1, 0, 1, "mid_spike");
    for (int i = 0; i < 9; i++) step(0, 1, 1, 0, 0, 0, 1, "mid_refract");
    step(1, 1, 1, 0, 0, 0, 0, "reset_in_refract");
    for (int i = 0; i < 7; i++) step(0, 1, 1, 0, 0, 8'(16 * (i + 1)), 0, "after_reset_ramp");
    step(0, 1, 1, 0, 1, 0, 1, "after_reset_spike");

    @(negedge clk);
    excIn = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lif_spike_neuron.md
Name: lif_spike_neuron

Overview:
- Leaky integrate-and-fire neuron that turns excitatory/inhibitory spike trains into a single-cycle output spike.
- Sits directly upstream of the 1-bit gait selection mux: two instances feed the mux data inputs (in1/in2), and the mux picks which neuron's spike drives the leg sequencer.
- Membrane potential is unsigned and saturating, with periodic shift-based leak and an absolute refractory period after each spike.

Parameters:
WIDTH, 8, membrane potential width in bits
W_EXC, 16, potential added per excitatory input cycle
W_INH, 16, potential subtracted per inhibitory input cycle
THRESH, 128, fire when next potential >= THRESH (must be <= 2^WIDTH-1)
LEAK_SHIFT, 3, leak amount per leak tick = potential >> LEAK_SHIFT
LEAK_PERIOD, 64, enabled cycles between leak ticks (>= 1)
REFRACT, 16, refractory length in enabled cycles (0 allowed)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
enable  input  1  advance neuron this cycle; low freezes all state
excIn  input  1  excitatory spike, sampled each enabled cycle
inhIn  input  1  inhibitory spike, sampled each enabled cycle
spikeOut  output  1  registered single-cycle output spike (to mux in1/in2)
potential  output  WIDTH  current membrane potential (registered)
refractory  output  1  high while in REFRACTORY state

Behaviour:
- Clock/reset: one clock, clk; rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: potential=0, spikeOut=0, refractory=0, state=INTEGRATE, leak counter=0, refractory counter=0. rst overrides enable and every other input, including mid-refractory.
- enable=0: all registers hold. spikeOut is forced to 0 the cycle after enable deasserts, so no spike is stretched.
- Leak counter: free-runs on enabled cycles in both states, 0..LEAK_PERIOD-1, then wraps. leakTick=1 when counter==LEAK_PERIOD-1.
- INTEGRATE, each enabled cycle:
  - next = pot + (excIn?W_EXC:0) - (inhIn?W_INH:0) - (leakTick ? pot>>LEAK_SHIFT : 0).
  - Leak is computed from the current pot, before the input terms are applied.
  - Compute next signed at WIDTH+2 bits, then clamp to [0, 2^WIDTH-1].
  - If clamped next >= THRESH: potential<=0, spikeOut<=1. If REFRACT>0, go to REFRACTORY with counter<=REFRACT and refractory<=1; if REFRACT==0, stay in INTEGRATE.
  - Otherwise: potential<=clamped next, spikeOut<=0.
- Latency: spikeOut rises on the clock edge that samples the crossing input, so it is visible one cycle after the input is presented. Pulse width is exactly 1 cycle.
- REFRACTORY, each enabled cycle:
  - excIn and inhIn are ignored; potential held at 0; spikeOut<=0; counter decrements.
  - When counter==1 on an enabled cycle: counter<=0, refractory<=0, next state INTEGRATE.
  - Inputs become effective on the first INTEGRATE cycle, so a spike is ignored for exactly REFRACT enabled cycles.
- Simultaneous excIn and inhIn: both terms apply (net W_EXC-W_INH).
- Underflow clamps to 0; overflow clamps to 2^WIDTH-1.
- Back-to-back spikes are possible only when REFRACT==0. The minimum spike interval is then ceil(THRESH/W_EXC) cycles.

Test Plan:
- Defaults, rst 2 cycles, enable=1, excIn=1 for 8 cycles -> potential 16,32,...,112; spikeOut=1 for exactly one cycle after the 8th sample; potential=0; refractory=1.
- Continue excIn=1 after that spike -> refractory high 16 cycles, potential stays 0, no spike; first exc after refractory drops gives potential=16.
- 5 excIn pulses (pot=80), then idle until leak tick at leak counter 63 -> potential 80->70; next tick 70->62.
- pot=32, excIn=inhIn=1 -> 32 unchanged; inhIn=1 three times from 32 -> 16, 0, 0 (clamp, no wrap).
- pot=48, enable=0 for 10 cycles with excIn=1 -> potential 48, leak counter frozen, spikeOut 0; re-enable resumes integration from 48.
- rst asserted at refractory counter=7 -> next cycle refractory=0, potential=0, state INTEGRATE; 8 excIn pulses spike again normally.
